// File: rtl/gnn_layer_engine.sv
// Time-multiplexed GNN layer: per node, sum the neighbour feature vectors, then apply an F_IN x F_OUT weight matrix.
// Optional build macro GNN_RELU_EN: out_data presents max(acc, 0) instead of the raw accumulator.
module gnn_layer_engine #(
    parameter int N_NODES = 4,
    parameter int F_IN    = 4,
    parameter int F_OUT   = 2,
    parameter int DW      = 5,
    parameter int AW      = 21
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_NODES*F_IN*DW-1:0]   x_in,
    input  logic [F_IN*F_OUT*DW-1:0]     w_in,
    input  logic [N_NODES*N_NODES-1:0]   adj_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [F_OUT*AW-1:0]          out_data,
    output logic [$clog2(N_NODES)-1:0]   out_node,
    output logic                         out_last,
    output logic                         busy
);

    localparam int NW = $clog2(N_NODES);
    localparam int KW = (F_IN > 1) ? $clog2(F_IN) : 1;
    localparam int GW = DW + NW;
    localparam int PW = GW + DW;

    typedef enum logic [1:0] {S_IDLE, S_AGG, S_MAC, S_OUT} state_t;

    state_t state_q, state_d;

    logic [NW-1:0] i_q, i_d;
    logic [NW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    logic signed [DW-1:0] x_q   [N_NODES][F_IN];
    logic signed [DW-1:0] x_d   [N_NODES][F_IN];
    logic signed [DW-1:0] w_q   [F_IN][F_OUT];
    logic signed [DW-1:0] w_d   [F_IN][F_OUT];
    logic [N_NODES-1:0]   adj_q [N_NODES];
    logic [N_NODES-1:0]   adj_d [N_NODES];
    logic signed [GW-1:0] agg_q [F_IN];
    logic signed [GW-1:0] agg_d [F_IN];
    logic signed [AW-1:0] acc_q [F_OUT];
    logic signed [AW-1:0] acc_d [F_OUT];
    logic signed [PW-1:0] prod  [F_OUT];

    logic i_last, j_last, k_last;

    assign i_last = (i_q == NW'(N_NODES - 1));
    assign j_last = (j_q == NW'(N_NODES - 1));
    assign k_last = (k_q == KW'(F_IN - 1));

`ifdef GNN_RELU_EN
    function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] v);
        return v[AW-1] ? '0 : v;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)  state_d = S_AGG;
            S_AGG:  if (j_last)    state_d = S_MAC;
            S_MAC:  if (k_last)    state_d = S_OUT;
            S_OUT:  if (out_ready) state_d = i_last ? S_IDLE : S_AGG;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_OUT);
        out_last  = (state_q == S_OUT) && i_last;
        out_node  = i_q;
        for (int o = 0; o < F_OUT; o++) begin
`ifdef GNN_RELU_EN
            out_data[o*AW +: AW] = relu(acc_q[o]);
`else
            out_data[o*AW +: AW] = acc_q[o];
`endif
        end
    end

    // Datapath: frame capture, neighbour aggregation, one-feature-per-cycle MAC
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        x_d   = x_q;
        w_d   = w_q;
        adj_d = adj_q;
        agg_d = agg_q;
        acc_d = acc_q;
        for (int o = 0; o < F_OUT; o++) begin
            prod[o] = PW'(agg_q[k_q]) * PW'(w_q[k_q][o]);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int n = 0; n < N_NODES; n++) begin
                        for (int f = 0; f < F_IN; f++) begin
                            x_d[n][f] = x_in[(n*F_IN+f)*DW +: DW];
                        end
                        for (int m = 0; m < N_NODES; m++) begin
                            adj_d[n][m] = adj_in[n*N_NODES+m];
                        end
                    end
                    for (int f = 0; f < F_IN; f++) begin
                        for (int o = 0; o < F_OUT; o++) begin
                            w_d[f][o] = w_in[(f*F_OUT+o)*DW +: DW];
                        end
                        agg_d[f] = '0;
                    end
                    i_d = '0;
                    j_d = '0;
                end
            end
            S_AGG: begin
                if (adj_q[i_q][j_q]) begin
                    for (int f = 0; f < F_IN; f++) begin
                        agg_d[f] = agg_q[f] + GW'(x_q[j_q][f]);
                    end
                end
                if (j_last) begin
                    k_d = '0;
                    for (int o = 0; o < F_OUT; o++) begin
                        acc_d[o] = '0;
                    end
                end else begin
                    j_d = j_q + NW'(1);
                end
            end
            S_MAC: begin
                for (int o = 0; o < F_OUT; o++) begin
                    acc_d[o] = acc_q[o] + AW'(prod[o]);
                end
                if (!k_last) begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + NW'(1);
                    for (int f = 0; f < F_IN; f++) begin
                        agg_d[f] = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            for (int n = 0; n < N_NODES; n++) begin
                for (int f = 0; f < F_IN; f++) begin
                    x_q[n][f] <= '0;
                end
                adj_q[n] <= '0;
            end
            for (int f = 0; f < F_IN; f++) begin
                for (int o = 0; o < F_OUT; o++) begin
                    w_q[f][o] <= '0;
                end
                agg_q[f] <= '0;
            end
            for (int o = 0; o < F_OUT; o++) begin
                acc_q[o] <= '0;
            end
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            x_q   <= x_d;
            w_q   <= w_d;
            adj_q <= adj_d;
            agg_q <= agg_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_gnn_layer_engine.sv
// Bench for gnn_layer_engine: directed frames checked every cycle against a plain-arithmetic graph-layer model.
module tb_gnn_layer_engine;

    localparam int N  = 4;
    localparam int FI = 4;
    localparam int FO = 2;
    localparam int DW = 5;
    localparam int AW = 21;
    localparam int NW = 2;
    localparam int GW = DW + NW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [N*FI*DW-1:0] x_in;
    logic [FI*FO*DW-1:0] w_in;
    logic [N*N-1:0]     adj_in;
    logic               out_valid;
    logic               out_ready;
    logic [FO*AW-1:0]   out_data;
    logic [NW-1:0]      out_node;
    logic               out_last;
    logic               busy;

    always #5 clk = ~clk;

    gnn_layer_engine #(
        .N_NODES(N), .F_IN(FI), .F_OUT(FO), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .adj_in(adj_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_node(out_node), .out_last(out_last),
        .busy(busy)
    );

    int         checks   = 0;
    int         failures = 0;
    int         xv [N][FI];
    int         wv [FI][FO];
    logic [N-1:0] arow [N];
    longint     exp_data [N][FO];
    int         exp_idx;
    bit         mon_en;
    logic       pre_valid, pre_ready, pre_last;
    logic [FO*AW-1:0] pre_data;
    logic [NW-1:0]    pre_node;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference: neighbour sum per feature, then matrix product, then wrap / optional clamp
    task automatic compute_model();
        longint agg [FI];
        longint s;
        for (int i = 0; i < N; i++) begin
            for (int f = 0; f < FI; f++) begin
                agg[f] = 0;
                for (int j = 0; j < N; j++) if (arow[i][j]) agg[f] += xv[j][f];
                agg[f] = wrapw(agg[f], GW);
            end
            for (int o = 0; o < FO; o++) begin
                s = 0;
                for (int f = 0; f < FI; f++) s += agg[f] * wv[f][o];
                s = wrapw(s, AW);
`ifdef GNN_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_data[i][o] = s;
            end
        end
    endtask

    task automatic monitor();
        if (!mon_en) return;
        if (pre_valid && pre_ready) begin
            exp_idx++;
            check("valid_falls_on_handshake", out_valid, 0);
        end
        if (pre_valid && !pre_ready) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_stable", out_data == pre_data, 1);
            check("stall_node_stable", out_node, pre_node);
            check("stall_last_stable", out_last, pre_last);
        end
        if (out_valid) begin
            if (exp_idx >= N) begin
                check("extra_output_index", exp_idx, N - 1);
            end else begin
                check("out_node", out_node, exp_idx);
                check("out_last", out_last, exp_idx == N - 1);
                for (int o = 0; o < FO; o++)
                    check($sformatf("out_data_n%0d_o%0d", exp_idx, o),
                          longint'($signed(out_data[o*AW +: AW])), exp_data[exp_idx][o]);
            end
        end
    endtask

    task automatic tick();
        pre_valid = out_valid;
        pre_ready = out_ready;
        pre_data  = out_data;
        pre_node  = out_node;
        pre_last  = out_last;
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic set_frame(input int xval, input int wval, input bit all_ones, input int zero_row);
        for (int n = 0; n < N; n++) for (int f = 0; f < FI; f++) xv[n][f] = xval;
        for (int f = 0; f < FI; f++) for (int o = 0; o < FO; o++) wv[f][o] = wval;
        if (all_ones) begin
            for (int n = 0; n < N; n++) arow[n] = '1;
        end else begin
            arow[0] = 4'b0111;
            arow[1] = 4'b1011;
            arow[2] = 4'b1101;
            arow[3] = 4'b1110;
        end
        if (zero_row >= 0) arow[zero_row] = '0;
    endtask

    task automatic start_frame();
        for (int n = 0; n < N; n++) begin
            for (int f = 0; f < FI; f++) x_in[(n*FI+f)*DW +: DW] = DW'(xv[n][f]);
            for (int m = 0; m < N; m++) adj_in[n*N+m] = arow[n][m];
        end
        for (int f = 0; f < FI; f++)
            for (int o = 0; o < FO; o++) w_in[(f*FO+o)*DW +: DW] = DW'(wv[f][o]);
        compute_model();
        exp_idx  = 0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (out_valid) break;
        end
        check("wait_valid_timeout", out_valid, 1);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (exp_idx < N && c < 300) begin
            tick();
            c++;
        end
        check("frame_done", exp_idx, N);
        check("in_ready_after_last", in_ready, 1);
        check("busy_after_last", busy, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_in = '0; w_in = '0; adj_in = '0;
        mon_en = 1'b0; exp_idx = 0;
        pre_valid = 0; pre_ready = 0; pre_data = '0; pre_node = '0; pre_last = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_node", out_node, 0);
        check("rst_out_last", out_last, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Test 1: default graph, all ones, out_ready high
        set_frame(1, 1, 0, -1);
        out_ready = 1'b1;
        start_frame();
        check("model_t1_pin", exp_data[2][1], 12);
        check("busy_after_accept", busy, 1);
        wait_valid(n);
        check("first_latency", n, 8);
        wait_done();

        // Test 2: extreme negatives, full adjacency
        set_frame(-16, -16, 1, -1);
        start_frame();
        check("model_t2_pin", exp_data[1][0], 4096);
        wait_done();

        // Test 3: backpressure on node 1
        set_frame(1, 1, 0, -1);
        out_ready = 1'b0;
        start_frame();
        wait_valid(n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(n);
        check("node1_latency", n, 8);
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(n);
        check("node2_latency_after_stall", n, 8);
        out_ready = 1'b1;
        wait_done();

        // Test 4: empty adjacency row, plus in_valid with junk while busy
        set_frame(3, 2, 0, 2);
        start_frame();
        check("model_t4_pin_zero", exp_data[2][0], 0);
        check("model_t4_pin_val", exp_data[0][1], 72);
        x_in = '1; w_in = '1; adj_in = '1;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        wait_done();

        // Test 5: asynchronous reset during node 1 MAC
        set_frame(1, 1, 0, -1);
        out_ready = 1'b0;
        start_frame();
        wait_valid(n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (6) tick();
        check("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_node", out_node, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        mon_en = 1'b1;
        out_ready = 1'b1;
        set_frame(-16, -16, 1, -1);
        start_frame();
        wait_valid(n);
        check("post_rst_latency", n, 8);
        wait_done();

        // Test 6: negative results, raw or clamped depending on build
        set_frame(1, -1, 0, -1);
        start_frame();
`ifdef GNN_RELU_EN
        check("model_t6_pin", exp_data[3][0], 0);
`else
        check("model_t6_pin", exp_data[3][0], -12);
`endif
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gnn_layer_engine.md
# gnn_layer_engine

Parametrised, time-multiplexed GNN layer for the accelerator. It captures a frame of node feature vectors, a weight matrix and a runtime adjacency mask. For each node in turn it sums the feature vectors of that node's neighbours, then multiplies the sum by the weight matrix. Results are emitted one node at a time over a valid/ready output. It replaces the fixed 4-node, hard-wired-graph datapath with a programmable-graph engine that uses F_OUT multipliers instead of one multiplier per edge. It can be chained behind itself for multi-layer networks.

## Interface
Parameters:
- N_NODES, 4, number of graph nodes (≥2)
- F_IN, 4, input features per node (≥1)
- F_OUT, 2, output features per node (≥1)
- DW, 5, signed width of each input feature and each weight
- AW, 21, signed width of each output accumulator (≥ DW+$clog2(N_NODES)+DW+$clog2(F_IN))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  input frame present
- in_ready  out  1  engine idle and able to accept a frame
- x_in  in  N_NODES*F_IN*DW  features; node n, feature f at slice [(n*F_IN+f)*DW +: DW]
- w_in  in  F_IN*F_OUT*DW  weights; w[f][o] at slice [(f*F_OUT+o)*DW +: DW]
- adj_in  in  N_NODES*N_NODES  bit [i*N_NODES+j]=1 means node i aggregates node j
- out_valid  out  1  out_data holds a node result
- out_ready  in  1  downstream accepts the result
- out_data  out  F_OUT*AW  output o at slice [o*AW +: AW]
- out_node  out  $clog2(N_NODES)  index of the node in out_data
- out_last  out  1  out_data is node N_NODES-1
- busy  out  1  frame in progress

## Operation
- A frame is accepted when in_valid && in_ready.
  - At acceptance, x_in, w_in and adj_in are registered in full.
  - After acceptance these inputs are don't-care until the next acceptance.
- States:
  - IDLE: in_ready=1, busy=0. On accept go to AGG with i=0, j=0 and the aggregate register cleared.
  - AGG: one neighbour per cycle. If adj[i][j]=1, agg[f] += x[j][f] for all f. At j=N_NODES-1 go to MAC with k=0 and the accumulators cleared; otherwise j++.
  - MAC: one input feature per cycle. acc[o] += agg[k]*w[k][o] for all o (F_OUT multipliers in parallel). At k=F_IN-1 go to OUT; otherwise k++.
  - OUT: out_valid=1 and out_data=acc; hold until out_ready.
    - On the handshake with i=N_NODES-1, go to IDLE.
    - Otherwise i++, clear agg and go to AGG with j=0.
- Self-loops are not implicit. The diagonal of adj is used exactly as loaded.
- Arithmetic is two's complement signed throughout:
  - aggregate width is DW+$clog2(N_NODES);
  - product width is aggregate width + DW;
  - the product is sign-extended to AW before accumulation;
  - the accumulator wraps on overflow, with no saturation.
- A node with an all-zero adjacency row outputs 0.
- in_valid outside IDLE is ignored. No frame is queued.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, in_ready=1, busy=0
  - out_valid=0, out_data=0, out_node=0, out_last=0
  - all internal registers 0
- out_valid rises on the (N_NODES+F_IN)th rising edge after the acceptance edge. With default parameters this is the 8th edge.
- Per node, the next out_valid rises N_NODES+F_IN edges after the previous output handshake edge.
- Frame throughput with out_ready tied high: N_NODES*(N_NODES+F_IN+1) cycles + 1 IDLE cycle.
- While out_valid=1 and out_ready=0, out_data, out_node and out_last are stable.
- out_valid falls on the handshake edge.
- in_ready is a function of state only. It rises on the edge that takes the final handshake into IDLE, so a new frame can be accepted on the next edge.
- Reset asserted mid-frame aborts the frame. Outputs take their reset values immediately and no partial result is emitted.

## Configuration
- GNN_RELU_EN defined:
  - the OUT stage presents max(acc[o], 0) per output;
  - a negative accumulator becomes 0 on out_data;
  - the internal accumulator is unchanged.
- GNN_RELU_EN undefined: out_data is the raw signed accumulator.

## Test plan
- Defaults, 4-node graph (node0 agg {0,1,2}, node1 {0,1,3}, node2 {0,2,3}, node3 {1,2,3}), all x=1, all w=1, out_ready=1 -> four outputs, each out_data = {12,12}. out_node runs 0..3, out_last=1 only on node 3, first out_valid 8 edges after accept.
- All x=-16, all w=-16, adj all ones -> agg=-64, every output 4*1024=4096, no wrap.
- Same frame as the first test, out_ready held low for 5 cycles on node 1 -> out_data/out_node stable for all 5 cycles; node 2 out_valid rises exactly 8 edges after the node-1 handshake.
- adj row 2 all zero, x=3, w=2 -> node 2 outputs {0,0}; the other nodes produce their normal values.
- rst_n pulsed low during node 1 MAC -> out_valid=0, out_data=0, busy=0 during reset; in_ready=1 after release; the next frame is processed from node 0 and produces correct results.
- x all 1, w all -1, first-test adjacency: GNN_RELU_EN undefined -> every output {-12,-12}; GNN_RELU_EN defined -> every output {0,0}.
